// File: rtl/exc_ctrl_if.sv
// WB-stage exception sequencer bus: pipeline/CP0 inputs and commit/redirect outputs.
// The master modport is the pipeline side and the slave modport is the sequencer.
interface exc_ctrl_if;
    logic        wb_valid;
    logic [7:0]  wb_exc_vec;
    logic        wb_eret;
    logic [31:0] wb_pc;
    logic        wb_is_bd;
    logic        status_ie;
    logic        status_exl;
    logic [7:0]  status_im;
    logic [1:0]  cause_ip_sw;
    logic [31:0] epc_in;
    logic [5:0]  ext_int;
    logic        compare_we;
    logic [31:0] compare_wdata;
    logic        fetch_ready;
    logic        exc_commit;
    logic        eret_commit;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_bd;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        int_pending;
    logic [31:0] count_out;

    modport master (
        output wb_valid, wb_exc_vec, wb_eret, wb_pc, wb_is_bd, status_ie, status_exl,
               status_im, cause_ip_sw, epc_in, ext_int, compare_we, compare_wdata, fetch_ready,
        input  exc_commit, eret_commit, exc_code, exc_epc, exc_bd, flush, redirect_valid,
               redirect_pc, int_pending, count_out
    );
    modport slave (
        input  wb_valid, wb_exc_vec, wb_eret, wb_pc, wb_is_bd, status_ie, status_exl,
               status_im, cause_ip_sw, epc_in, ext_int, compare_we, compare_wdata, fetch_ready,
        output exc_commit, eret_commit, exc_code, exc_epc, exc_bd, flush, redirect_valid,
               redirect_pc, int_pending, count_out
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer for the WB-stage CP0: commit pulse, flush, fetch redirect,
// plus the Count/Compare timer and the interrupt-pending tag for decode.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic       clk,
    input logic       rst,
    exc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] target, target_n;
    logic        exc_commit_q, exc_commit_n;
    logic        eret_commit_q, eret_commit_n;
    logic [4:0]  code_q, code_n, code_sel;
    logic [31:0] epc_q, epc_n;
    logic        bd_q, bd_n;
    logic        exc, ert;

    logic [31:0] count, compare;
    logic        half, timer_ip;
    logic [7:0]  ip;

    assign exc = bus.wb_valid & (|bus.wb_exc_vec);
    assign ert = bus.wb_valid & bus.wb_eret & ~exc;

    // Vector bits: {ADES,ADEL_D,OV,INT,SYSCALL,BREAK,RI,ADEL_F}
    always_comb begin
        code_sel = 5'd0;
        if      (bus.wb_exc_vec[4]) code_sel = 5'd0;
        else if (bus.wb_exc_vec[0]) code_sel = 5'd4;
        else if (bus.wb_exc_vec[1]) code_sel = 5'd10;
        else if (bus.wb_exc_vec[2]) code_sel = 5'd9;
        else if (bus.wb_exc_vec[3]) code_sel = 5'd8;
        else if (bus.wb_exc_vec[5]) code_sel = 5'd12;
        else if (bus.wb_exc_vec[6]) code_sel = 5'd4;
        else if (bus.wb_exc_vec[7]) code_sel = 5'd5;
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        target_n      = target;
        exc_commit_n  = 1'b0;
        eret_commit_n = 1'b0;
        code_n        = code_q;
        epc_n         = epc_q;
        bd_n          = bd_q;
        case (state)
            IDLE: begin
                if (exc) begin
                    exc_commit_n = 1'b1;
                    code_n       = code_sel;
                    epc_n        = bus.wb_is_bd ? bus.wb_pc - 32'd4 : bus.wb_pc;
                    bd_n         = bus.wb_is_bd;
                    target_n     = EXC_VECTOR;
                    cnt_n        = FLUSH_INIT;
                    state_n      = FLUSH;
                end else if (ert) begin
                    eret_commit_n = 1'b1;
                    target_n      = bus.epc_in;
                    cnt_n         = FLUSH_INIT;
                    state_n       = FLUSH;
                end
            end
            // WB contents are being killed here, so any new trigger is dropped
            FLUSH: begin
                if (cnt == 4'd0) state_n = REDIRECT;
                else             cnt_n   = cnt - 4'd1;
            end
            REDIRECT: if (bus.fetch_ready) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            target        <= 32'd0;
            exc_commit_q  <= 1'b0;
            eret_commit_q <= 1'b0;
            code_q        <= 5'd0;
            epc_q         <= 32'd0;
            bd_q          <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            target        <= target_n;
            exc_commit_q  <= exc_commit_n;
            eret_commit_q <= eret_commit_n;
            code_q        <= code_n;
            epc_q         <= epc_n;
            bd_q          <= bd_n;
        end
    end

    // Count ticks every other clk; a Compare write always beats a same-cycle match
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 32'd0;
            compare  <= 32'hFFFF_FFFF;
            half     <= 1'b0;
            timer_ip <= 1'b0;
        end else begin
            half <= ~half;
            if (half) count <= count + 32'd1;
            if (bus.compare_we) begin
                compare  <= bus.compare_wdata;
                timer_ip <= 1'b0;
            end else if (half && count == compare) begin
                timer_ip <= 1'b1;
            end
        end
    end

    assign ip = {timer_ip | bus.ext_int[5], bus.ext_int[4:0], bus.cause_ip_sw};

    assign bus.exc_commit     = exc_commit_q;
    assign bus.eret_commit    = eret_commit_q;
    assign bus.exc_code       = code_q;
    assign bus.exc_epc        = epc_q;
    assign bus.exc_bd         = bd_q;
    assign bus.flush          = (state != IDLE);
    assign bus.redirect_valid = (state == REDIRECT);
    assign bus.redirect_pc    = target;
    assign bus.int_pending    = bus.status_ie & ~bus.status_exl & (|(ip & bus.status_im));
    assign bus.count_out      = count;
endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: table of directed transactions, hand-written corner sequences,
// then random transactions checked against a transaction-level model and a timer model.
module tb_exc_ctrl;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

  logic clk, rst;
  exc_ctrl_if bus();

  exc_ctrl #(.EXC_VECTOR(EXC_VECTOR), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [7:0]  vec;
    logic        eret;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] epc_in;
    int          lat;
    logic        exp_exc;
    logic        exp_eret;
    logic [4:0]  exp_code;
    logic [31:0] exp_epc;
    logic        exp_bd;
    logic [31:0] exp_tgt;
  } txn_t;

  int n_vec = 0;
  int n_err = 0;

  // Timer model: count is simply half the number of clock edges since reset
  longint      m_e   = 0;
  logic [31:0] m_cmp = 32'hFFFF_FFFF;
  logic        m_ip  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_e <= 0; m_cmp <= 32'hFFFF_FFFF; m_ip <= 1'b0;
    end else begin
      if (bus.compare_we) begin
        m_cmp <= bus.compare_wdata; m_ip <= 1'b0;
      end else if ((m_e % 2) == 1 && 32'(m_e / 2) == m_cmp) begin
        m_ip <= 1'b1;
      end
      m_e <= m_e + 1;
    end
  end

  function automatic logic exp_int();
    logic [7:0] ipv;
    ipv = {m_ip | bus.ext_int[5], bus.ext_int[4:0], bus.cause_ip_sw};
    return bus.status_ie & ~bus.status_exl & (|(ipv & bus.status_im));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    chk("count_out", bus.count_out, 32'(m_e >> 1));
    chk("int_pending", 32'(bus.int_pending), 32'(exp_int()));
  endtask

  // Reference: first set cause in priority order wins; ERET only without exception
  function automatic txn_t ref_model(input txn_t t);
    int bit_ord[8] = '{4, 0, 1, 2, 3, 5, 6, 7};
    int code_ord[8] = '{0, 4, 10, 9, 8, 12, 4, 5};
    txn_t r = t;
    r.exp_exc = 0; r.exp_eret = 0; r.exp_code = 0; r.exp_epc = 0; r.exp_bd = 0; r.exp_tgt = 0;
    if (t.valid && t.vec != 0) begin
      r.exp_exc = 1;
      for (int i = 7; i >= 0; i--)
        if (t.vec[bit_ord[i]]) r.exp_code = 5'(code_ord[i]);
      r.exp_epc = t.bd ? t.pc - 32'd4 : t.pc;
      r.exp_bd  = t.bd;
      r.exp_tgt = EXC_VECTOR;
    end else if (t.valid && t.eret) begin
      r.exp_eret = 1;
      r.exp_tgt  = t.epc_in;
    end
    return r;
  endfunction

  task automatic junk_wb();
    bus.wb_valid   = 1'b1;
    bus.wb_exc_vec = 8'($urandom_range(1, 255));
    bus.wb_eret    = 1'b1;
    bus.wb_pc      = $urandom;
    bus.epc_in     = $urandom;
  endtask

  task automatic run_txn(input txn_t t);
    bus.wb_valid = t.valid; bus.wb_exc_vec = t.vec; bus.wb_eret = t.eret;
    bus.wb_is_bd = t.bd; bus.wb_pc = t.pc; bus.epc_in = t.epc_in; bus.fetch_ready = 1'b0;
    step();
    chk("exc_commit", 32'(bus.exc_commit), 32'(t.exp_exc));
    chk("eret_commit", 32'(bus.eret_commit), 32'(t.exp_eret));
    if (!t.exp_exc && !t.exp_eret) begin
      chk("flush idle", 32'(bus.flush), 0);
      bus.wb_valid = 1'b0;
      return;
    end
    if (t.exp_exc) begin
      chk("exc_code", 32'(bus.exc_code), 32'(t.exp_code));
      chk("exc_epc", bus.exc_epc, t.exp_epc);
      chk("exc_bd", 32'(bus.exc_bd), 32'(t.exp_bd));
    end
    chk("flush start", 32'(bus.flush), 1);
    junk_wb();
    for (int i = 0; i < int'(FLUSH_CYCLES); i++) begin
      step();
      chk("pulse width", 32'({bus.exc_commit, bus.eret_commit}), 0);
      chk("flush hold", 32'(bus.flush), 1);
      chk("early redirect", 32'(bus.redirect_valid), 0);
    end
    step();
    chk("redirect_valid", 32'(bus.redirect_valid), 1);
    chk("redirect flush", 32'(bus.flush), 1);
    chk("redirect_pc", bus.redirect_pc, t.exp_tgt);
    chk("no 2nd pulse", 32'({bus.exc_commit, bus.eret_commit}), 0);
    for (int i = 0; i < t.lat; i++) begin
      step();
      chk("redirect wait", 32'(bus.redirect_valid), 1);
      chk("redirect_pc hold", bus.redirect_pc, t.exp_tgt);
    end
    bus.fetch_ready = 1'b1;
    step();
    chk("flush drop", 32'(bus.flush), 0);
    chk("redirect drop", 32'(bus.redirect_valid), 0);
    chk("discarded trig", 32'({bus.exc_commit, bus.eret_commit}), 0);
    bus.fetch_ready = 1'b0;
    bus.wb_valid = 1'b0;
  endtask

  function automatic txn_t mk(input logic v, input logic [7:0] vec, input logic e, input logic bd,
                              input logic [31:0] pc, input logic [31:0] epi, input int lat,
                              input logic xe, input logic xr, input logic [4:0] xc,
                              input logic [31:0] xepc, input logic xbd, input logic [31:0] xt);
    txn_t r;
    r.valid = v; r.vec = vec; r.eret = e; r.bd = bd; r.pc = pc; r.epc_in = epi; r.lat = lat;
    r.exp_exc = xe; r.exp_eret = xr; r.exp_code = xc; r.exp_epc = xepc; r.exp_bd = xbd;
    r.exp_tgt = xt;
    return r;
  endfunction

  txn_t tbl[13];
  txn_t rt;

  initial begin
    tbl[0]  = mk(1, 8'h09, 0, 0, 32'h80001000, 0, 2, 1, 0, 4, 32'h80001000, 0, 32'hBFC00380);
    tbl[1]  = mk(1, 8'h20, 0, 1, 32'h80000008, 0, 4, 1, 0, 12, 32'h80000004, 1, 32'hBFC00380);
    tbl[2]  = mk(1, 8'h00, 1, 0, 32'h80003000, 32'h80002000, 1, 0, 1, 0, 0, 0, 32'h80002000);
    tbl[3]  = mk(1, 8'h10, 1, 0, 32'h80004000, 32'h80002000, 0, 1, 0, 0, 32'h80004000, 0, 32'hBFC00380);
    tbl[4]  = mk(1, 8'h02, 0, 0, 32'h80005000, 0, 0, 1, 0, 10, 32'h80005000, 0, 32'hBFC00380);
    tbl[5]  = mk(1, 8'h0C, 0, 0, 32'h80005004, 0, 1, 1, 0, 9, 32'h80005004, 0, 32'hBFC00380);
    tbl[6]  = mk(1, 8'h08, 0, 0, 32'h80005008, 0, 0, 1, 0, 8, 32'h80005008, 0, 32'hBFC00380);
    tbl[7]  = mk(1, 8'hC0, 0, 0, 32'h8000500C, 0, 0, 1, 0, 4, 32'h8000500C, 0, 32'hBFC00380);
    tbl[8]  = mk(1, 8'h80, 0, 0, 32'h80005010, 0, 0, 1, 0, 5, 32'h80005010, 0, 32'hBFC00380);
    tbl[9]  = mk(1, 8'hFF, 1, 0, 32'h80005014, 0, 0, 1, 0, 0, 32'h80005014, 0, 32'hBFC00380);
    tbl[10] = mk(1, 8'h02, 0, 1, 32'h00000000, 0, 0, 1, 0, 10, 32'hFFFFFFFC, 1, 32'hBFC00380);
    tbl[11] = mk(1, 8'h00, 0, 0, 32'h80006000, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 8'hFF, 1, 1, 32'h80007000, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1;
    bus.wb_valid = 0; bus.wb_exc_vec = 0; bus.wb_eret = 0; bus.wb_pc = 0; bus.wb_is_bd = 0;
    bus.status_ie = 0; bus.status_exl = 0; bus.status_im = 0; bus.cause_ip_sw = 0;
    bus.epc_in = 0; bus.ext_int = 0; bus.compare_we = 0; bus.compare_wdata = 0;
    bus.fetch_ready = 0;
    step(); step();
    chk("rst exc_commit", 32'(bus.exc_commit), 0);
    chk("rst eret_commit", 32'(bus.eret_commit), 0);
    chk("rst flush", 32'(bus.flush), 0);
    chk("rst redirect_valid", 32'(bus.redirect_valid), 0);
    chk("rst redirect_pc", bus.redirect_pc, 0);
    chk("rst exc_epc", bus.exc_epc, 0);
    chk("rst count", bus.count_out, 0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_txn(tbl[i]);

    // Reset while waiting in REDIRECT: everything drops at the next edge
    bus.wb_valid = 1; bus.wb_exc_vec = 8'h01; bus.wb_pc = 32'h80008000; bus.wb_is_bd = 0;
    step();
    bus.wb_valid = 0;
    repeat (FLUSH_CYCLES + 1) step();
    chk("pre-rst redirect", 32'(bus.redirect_valid), 1);
    rst = 1'b1;
    step();
    chk("mid-rst flush", 32'(bus.flush), 0);
    chk("mid-rst redirect", 32'(bus.redirect_valid), 0);
    chk("mid-rst count", bus.count_out, 0);
    chk("mid-rst commit", 32'({bus.exc_commit, bus.eret_commit}), 0);
    rst = 1'b0;

    // Timer: Compare=3 fires on the increment edge where Count already reads 3
    bus.status_ie = 1; bus.status_exl = 0; bus.status_im = 8'h80;
    bus.compare_we = 1; bus.compare_wdata = 32'd3;
    step();
    bus.compare_we = 0;
    repeat (6) step();
    chk("timer not yet", 32'(bus.int_pending), 0);
    repeat (2) step();
    chk("timer int", 32'(bus.int_pending), 1);
    bus.status_exl = 1;
    #1 chk("exl masks", 32'(bus.int_pending), 0);
    bus.status_exl = 0;
    bus.compare_we = 1; bus.compare_wdata = 32'd100;
    step();
    chk("compare_we clears", 32'(bus.int_pending), 0);
    bus.compare_we = 0;

    for (int n = 0; n < 200; n++) begin
      bus.status_ie = 1'($urandom); bus.status_exl = 1'($urandom);
      bus.status_im = 8'($urandom); bus.cause_ip_sw = 2'($urandom);
      bus.ext_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      rt.valid  = ($urandom_range(0, 7) != 0);
      rt.vec    = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
      rt.eret   = 1'($urandom);
      rt.bd     = 1'($urandom);
      rt.pc     = $urandom;
      rt.epc_in = $urandom;
      rt.lat    = $urandom_range(0, 3);
      run_txn(ref_model(rt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
